// File: rtl/clock_config_arbiter.sv
// rtl/clock_config_arbiter.sv - round-robin config arbiter that applies legal period/duty at generator boundaries
module clock_config_arbiter #(
    parameter int WIDTH      = 8,
    parameter int PERIOD_RST = 2,
    parameter int DUTY_RST   = 1
) (
    input  logic             i_fast_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [WIDTH-1:0] i_req_period0,
    input  logic [WIDTH-1:0] i_req_period1,
    input  logic [WIDTH-1:0] i_req_duty0,
    input  logic [WIDTH-1:0] i_req_duty1,
    output logic             o_gen_enable,
    output logic [WIDTH-1:0] o_gen_period,
    output logic [WIDTH-1:0] o_gen_duty_cycle,
    output logic             o_gen_clear,
    output logic             o_cfg_done,
    output logic             o_cfg_err,
    output logic             o_cfg_src
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_configured;
    logic [WIDTH-1:0] r_mirror;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_duty;
    logic             r_gen_enable;
    logic [WIDTH-1:0] r_gen_period;
    logic [WIDTH-1:0] r_gen_duty;
    logic             r_gen_clear;
    logic             r_cfg_done;
    logic             r_cfg_err;
    logic             r_cfg_src;

    logic             w_grant;
    logic             w_accept;
    logic             w_illegal;
    logic             w_at_last;
    logic             w_apply;
    logic [WIDTH-1:0] w_last;

    // r_ptr holds the requester favoured when both are valid
    assign w_grant     = (i_req_valid == 2'b11) ? r_ptr : i_req_valid[1];
    assign o_req_ready = (r_state == S_IDLE) ? ((w_grant ? 2'b10 : 2'b01) & i_req_valid) : 2'b00;
    assign w_accept    = |o_req_ready;

    assign w_last    = r_gen_period - WIDTH'(1);
    assign w_illegal = (r_pend_period < WIDTH'(2)) || (r_pend_duty > r_pend_period);
    assign w_at_last = r_gen_enable && (r_mirror == w_last);
    // Disabled generator: apply at once with a clear; running: only on the wrap edge
    assign w_apply   = ((r_state == S_CHECK) && !w_illegal && !r_gen_enable)
                    || ((r_state == S_WAIT) && (!r_gen_enable || w_at_last));

    always_ff @(posedge i_fast_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= 1'b0;
            r_configured  <= 1'b0;
            r_mirror      <= '0;
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_gen_enable  <= 1'b0;
            r_gen_period  <= WIDTH'(PERIOD_RST);
            r_gen_duty    <= WIDTH'(DUTY_RST);
            r_gen_clear   <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_cfg_src     <= 1'b0;
        end else begin
            r_gen_clear  <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_gen_enable <= i_run & r_configured;

            if (r_gen_clear) begin
                r_mirror <= '0;
            end else if (r_gen_enable) begin
                r_mirror <= w_at_last ? '0 : r_mirror + WIDTH'(1);
            end

            if (w_apply) begin
                r_gen_period <= r_pend_period;
                r_gen_duty   <= r_pend_duty;
                r_gen_clear  <= !r_gen_enable;
                r_cfg_done   <= 1'b1;
                r_configured <= 1'b1;
                r_state      <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_pend_period <= w_grant ? i_req_period1 : i_req_period0;
                            r_pend_duty   <= w_grant ? i_req_duty1 : i_req_duty0;
                            r_cfg_src     <= w_grant;
                            r_ptr         <= ~w_grant;
                            r_state       <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (w_illegal) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state   <= S_WAIT;
                        end
                    end
                    S_WAIT:  r_state <= S_WAIT;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_gen_enable     = r_gen_enable;
    assign o_gen_period     = r_gen_period;
    assign o_gen_duty_cycle = r_gen_duty;
    assign o_gen_clear      = r_gen_clear;
    assign o_cfg_done       = r_cfg_done;
    assign o_cfg_err        = r_cfg_err;
    assign o_cfg_src        = r_cfg_src;
endmodule
